rect_fill_engine: RTL

- Parametrised successor to the full-screen clear datapath.
- Rasterises an arbitrary rectangle (origin, width, height) in one colour into the VGA pixel-write stream, one pixel per accepted cycle.
- Provides a start/busy/done handshake, screen-edge clipping and downstream back-pressure.
- Sits between the game-control FSM (clear, game-over, sprite erase) and the VGA adapter write port.

---
 rtl/rect_fill_if.sv | 44 ++++
 rtl/rect_fill_engine.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/rect_fill_if.sv
// Pixel-fill request/stream bundle between the game-control FSM and the rectangle fill engine.
// RECT_FILL_CHECKER_EN adds the checkerboard request bit.
interface rect_fill_if #(
  parameter int X_W     = 8,
  parameter int Y_W     = 7,
  parameter int COLOR_W = 3
);
  logic               start;
  logic [X_W-1:0]     x0;
  logic [Y_W-1:0]     y0;
  logic [X_W-1:0]     w;
  logic [Y_W-1:0]     h;
  logic [COLOR_W-1:0] color_in;
`ifdef RECT_FILL_CHECKER_EN
  logic               checkerboard;
`endif
  logic               out_ready;
  logic [X_W-1:0]     x_out;
  logic [Y_W-1:0]     y_out;
  logic [COLOR_W-1:0] color_out;
  logic               plot;
  logic               busy;
  logic               done;

`ifdef RECT_FILL_CHECKER_EN
  modport master (
    output start, x0, y0, w, h, color_in, checkerboard, out_ready,
    input  x_out, y_out, color_out, plot, busy, done
  );
  modport slave (
    input  start, x0, y0, w, h, color_in, checkerboard, out_ready,
    output x_out, y_out, color_out, plot, busy, done
  );
`else
  modport master (
    output start, x0, y0, w, h, color_in, out_ready,
    input  x_out, y_out, color_out, plot, busy, done
  );
  modport slave (
    input  start, x0, y0, w, h, color_in, out_ready,
    output x_out, y_out, color_out, plot, busy, done
  );
`endif
endinterface

// File: rtl/rect_fill_engine.sv
// Rasterises a clipped, single-colour rectangle into the VGA pixel-write stream, one pixel per accepted cycle.
// Optional checkerboard colouring is enabled with the macro RECT_FILL_CHECKER_EN.
module rect_fill_engine #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOR_W  = 3,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input logic       clk,
  input logic       reset_n,
  rect_fill_if.slave bus
);

  localparam logic [X_W:0]   SCREEN_W_C = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0]   SCREEN_H_C = (Y_W+1)'(SCREEN_H);
  localparam logic [X_W-1:0] ONE_X      = X_W'(1);
  localparam logic [Y_W-1:0] ONE_Y      = Y_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_nxt;

  logic [X_W-1:0]     cnt_x, cnt_x_nxt;
  logic [Y_W-1:0]     cnt_y, cnt_y_nxt;
  logic [X_W-1:0]     lat_x0, lat_x0_nxt;
  logic [Y_W-1:0]     lat_y0, lat_y0_nxt;
  logic [X_W-1:0]     lat_w, lat_w_nxt;
  logic [Y_W-1:0]     lat_h, lat_h_nxt;
  logic [COLOR_W-1:0] lat_color, lat_color_nxt;
`ifdef RECT_FILL_CHECKER_EN
  logic               lat_chk, lat_chk_nxt;
`endif

  logic [X_W-1:0]     x_out_r, x_out_nxt;
  logic [Y_W-1:0]     y_out_r, y_out_nxt;
  logic [COLOR_W-1:0] color_r, color_nxt;
  logic               plot_r, plot_nxt;

  // Pixel-generation operands: either the new request (on start) or the next raster position.
  logic [X_W-1:0]     px_x0, px_cx, adv_x;
  logic [Y_W-1:0]     px_y0, px_cy, adv_y;
  logic [COLOR_W-1:0] px_color;
  logic               px_chk;
  logic               last_x, last_y, load_px;
  logic [X_W:0]       x_sum;
  logic [Y_W:0]       y_sum;

  // Sums are one bit wider than the outputs so that wrap-around never looks on-screen.
  function automatic logic is_visible(input logic [X_W:0] xs, input logic [Y_W:0] ys);
    return (xs < SCREEN_W_C) && (ys < SCREEN_H_C);
  endfunction

  function automatic logic [COLOR_W-1:0] pixel_color(input logic [COLOR_W-1:0] c,
                                                     input logic invert);
    return invert ? ~c : c;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt_x     <= '0;
      cnt_y     <= '0;
      lat_x0    <= '0;
      lat_y0    <= '0;
      lat_w     <= '0;
      lat_h     <= '0;
      lat_color <= '0;
`ifdef RECT_FILL_CHECKER_EN
      lat_chk   <= 1'b0;
`endif
      x_out_r   <= '0;
      y_out_r   <= '0;
      color_r   <= '0;
      plot_r    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt_x     <= cnt_x_nxt;
      cnt_y     <= cnt_y_nxt;
      lat_x0    <= lat_x0_nxt;
      lat_y0    <= lat_y0_nxt;
      lat_w     <= lat_w_nxt;
      lat_h     <= lat_h_nxt;
      lat_color <= lat_color_nxt;
`ifdef RECT_FILL_CHECKER_EN
      lat_chk   <= lat_chk_nxt;
`endif
      x_out_r   <= x_out_nxt;
      y_out_r   <= y_out_nxt;
      color_r   <= color_nxt;
      plot_r    <= plot_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_x_nxt     = cnt_x;
    cnt_y_nxt     = cnt_y;
    lat_x0_nxt    = lat_x0;
    lat_y0_nxt    = lat_y0;
    lat_w_nxt     = lat_w;
    lat_h_nxt     = lat_h;
    lat_color_nxt = lat_color;
`ifdef RECT_FILL_CHECKER_EN
    lat_chk_nxt   = lat_chk;
`endif
    x_out_nxt     = x_out_r;
    y_out_nxt     = y_out_r;
    color_nxt     = color_r;
    plot_nxt      = plot_r;
    load_px       = 1'b0;

    last_x = (cnt_x == lat_w - ONE_X);
    last_y = (cnt_y == lat_h - ONE_Y);
    adv_x  = last_x ? '0 : cnt_x + ONE_X;
    adv_y  = last_x ? cnt_y + ONE_Y : cnt_y;

    px_x0    = lat_x0;
    px_y0    = lat_y0;
    px_cx    = adv_x;
    px_cy    = adv_y;
    px_color = lat_color;
`ifdef RECT_FILL_CHECKER_EN
    px_chk   = lat_chk;
`else
    px_chk   = 1'b0;
`endif

    case (state)
      IDLE: begin
        if (bus.start) begin
          lat_x0_nxt    = bus.x0;
          lat_y0_nxt    = bus.y0;
          lat_w_nxt     = bus.w;
          lat_h_nxt     = bus.h;
          lat_color_nxt = bus.color_in;
`ifdef RECT_FILL_CHECKER_EN
          lat_chk_nxt   = bus.checkerboard;
`endif
          cnt_x_nxt     = '0;
          cnt_y_nxt     = '0;
          if (bus.w == '0 || bus.h == '0) begin
            state_nxt = DONE;
          end else begin
            state_nxt = FILL;
            px_x0     = bus.x0;
            px_y0     = bus.y0;
            px_cx     = '0;
            px_cy     = '0;
            px_color  = bus.color_in;
`ifdef RECT_FILL_CHECKER_EN
            px_chk    = bus.checkerboard;
`endif
            load_px   = 1'b1;
          end
        end
      end
      FILL: begin
        // Off-screen pixels never wait for the downstream write port.
        if (bus.out_ready || !plot_r) begin
          if (last_x && last_y) begin
            state_nxt = DONE;
            plot_nxt  = 1'b0;
          end else begin
            cnt_x_nxt = adv_x;
            cnt_y_nxt = adv_y;
            load_px   = 1'b1;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    x_sum = {1'b0, px_x0} + {1'b0, px_cx};
    y_sum = {1'b0, px_y0} + {1'b0, px_cy};
    if (load_px) begin
      x_out_nxt = x_sum[X_W-1:0];
      y_out_nxt = y_sum[Y_W-1:0];
      color_nxt = pixel_color(px_color, px_chk & (px_cx[0] ^ px_cy[0]));
      plot_nxt  = is_visible(x_sum, y_sum);
    end
  end

  assign bus.x_out     = x_out_r;
  assign bus.y_out     = y_out_r;
  assign bus.color_out = color_r;
  assign bus.plot      = plot_r;
  assign bus.busy      = (state == FILL);
  assign bus.done      = (state == DONE);

endmodule
